dmem_arbiter: RTL and testbench

- Two-requester arbiter for the single-port data memory.
- Requester 0 is the core load/store unit. Requester 1 is the debug/loader port used by benches and the future UART loader.
- Round-robin grant, one outstanding access at a time, fixed memory read latency, and out-of-range address detection with an error response.
- Sits between the core/loader and the data memory inside the riscv top.

---
 rtl/dmem_arbiter_pkg.sv | 19 +
 rtl/dmem_arbiter_if.sv | 28 ++
 rtl/dmem_rr_pick.sv | 20 ++
 rtl/dmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds FSM state encodings, the latency counter width and the default data width.
package dmem_arbiter_pkg;

  localparam int CPU_WIDTH  = 32;
  localparam int DMEM_LAT_W = 3;

  typedef enum logic [1:0] {
    DMEM_ARB_IDLE  = 2'd0,
    DMEM_ARB_ISSUE = 2'd1,
    DMEM_ARB_WAIT  = 2'd2,
    DMEM_ARB_RESP  = 2'd3
  } dmem_arb_state_e;

  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side request/response bundle for one data-memory client.
// Request uses valid/ready; the response is a single-cycle strobe with no back-pressure.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = CPU_WIDTH
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_wstrb;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker: on a tie the requester that did not win last time is chosen.
// Purely combinational; gnt is one-hot or zero when nobody requests.
module dmem_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt_id = 1'b0;
    if (req == 2'b11) begin
      gnt_id = ~last_grant;
    end else if (req == 2'b10) begin
      gnt_id = 1'b1;
    end
    gnt = (req == 2'b00) ? 2'b00 : (gnt_id ? 2'b10 : 2'b01);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the single-port data memory, one access in flight at a time.
// Read rsp at accept+2+MEM_LAT, write at +2, range error at +1; requests wait (ready low) outside IDLE.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = CPU_WIDTH,
  parameter int MEM_DEPTH = 1024,
  parameter int MEM_LAT   = 1
) (
  input  logic            clk,
  input  logic            rst,
  dmem_arbiter_if.slave   m0,
  dmem_arbiter_if.slave   m1,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-3:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam logic [AW:0]           ADDR_LIMIT = (AW + 1)'(MEM_DEPTH) << 2;
  localparam logic [DMEM_LAT_W-1:0] LAT_LAST   = DMEM_LAT_W'(MEM_LAT);

  dmem_arb_state_e       state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  gnt_id_q, gnt_id_d;
  logic [DMEM_LAT_W-1:0] cnt_q, cnt_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [DW/8-1:0]       mem_wstrb_q, mem_wstrb_d;
  logic [AW-3:0]         mem_addr_q, mem_addr_d;
  logic [DW-1:0]         mem_wdata_q, mem_wdata_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]         rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [1:0]      pick_gnt;
  logic            pick_id;
  logic            in_idle;
  logic            accept;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [DW/8-1:0] sel_wstrb;
  logic            sel_legal;

  dmem_rr_pick u_pick (
    .req        ({m1.req_valid, m0.req_valid}),
    .last_grant (last_grant_q),
    .gnt        (pick_gnt),
    .gnt_id     (pick_id)
  );

  assign in_idle      = (state_q == DMEM_ARB_IDLE);
  assign accept       = in_idle && (pick_gnt != 2'b00);
  assign m0.req_ready = in_idle && pick_gnt[0];
  assign m1.req_ready = in_idle && pick_gnt[1];

  assign sel_we    = pick_id ? m1.req_we    : m0.req_we;
  assign sel_addr  = pick_id ? m1.req_addr  : m0.req_addr;
  assign sel_wdata = pick_id ? m1.req_wdata : m0.req_wdata;
  assign sel_wstrb = pick_id ? m1.req_wstrb : m0.req_wstrb;
  assign sel_legal = ({1'b0, sel_addr} < ADDR_LIMIT);

  // mem_wstrb/addr/wdata double as the latched request; only en/we drop back to 0.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_id_d     = gnt_id_q;
    cnt_d        = cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_wstrb_d  = mem_wstrb_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rsp_valid_d  = 2'b00;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;

    case (state_q)
      DMEM_ARB_IDLE: begin
        if (accept) begin
          last_grant_d = pick_id;
          gnt_id_d     = pick_id;
          if (sel_legal) begin
            state_d     = DMEM_ARB_ISSUE;
            mem_en_d    = 1'b1;
            mem_we_d    = sel_we;
            mem_wstrb_d = sel_wstrb;
            mem_addr_d  = sel_addr[AW-1:2];
            mem_wdata_d = sel_wdata;
          end else begin
            state_d     = DMEM_ARB_RESP;
            rsp_valid_d = id_onehot(pick_id);
            rsp_err_d   = 1'b1;
          end
        end
      end
      DMEM_ARB_ISSUE: begin
        if (mem_we_q) begin
          state_d     = DMEM_ARB_RESP;
          rsp_valid_d = id_onehot(gnt_id_q);
        end else begin
          state_d = DMEM_ARB_WAIT;
          cnt_d   = DMEM_LAT_W'(1);
        end
      end
      DMEM_ARB_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          state_d     = DMEM_ARB_RESP;
          cnt_d       = '0;
          rsp_valid_d = id_onehot(gnt_id_q);
          rsp_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DMEM_ARB_RESP: begin
        state_d = DMEM_ARB_IDLE;
      end
      default: begin
        state_d = DMEM_ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= DMEM_ARB_IDLE;
      last_grant_q <= 1'b1;
      gnt_id_q     <= 1'b0;
      cnt_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wstrb_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_id_q     <= gnt_id_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Response payload is only presented to the requester that owns the strobe.
  assign m0.rsp_valid = rsp_valid_q[0];
  assign m0.rsp_rdata = rsp_valid_q[0] ? rsp_rdata_q : '0;
  assign m0.rsp_err   = rsp_valid_q[0] && rsp_err_q;
  assign m1.rsp_valid = rsp_valid_q[1];
  assign m1.rsp_rdata = rsp_valid_q[1] ? rsp_rdata_q : '0;
  assign m1.rsp_err   = rsp_valid_q[1] && rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) with behavioural memories.
// Expected responses are queued at request acceptance and checked when the strobe appears.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Index [d][r]: d=0 is the MEM_LAT=1 instance, d=1 the MEM_LAT=3 instance; r is the requester.
  logic        drv_v     [2][2];
  logic        drv_we    [2][2];
  logic [31:0] drv_addr  [2][2];
  logic [31:0] drv_wdata [2][2];
  logic [3:0]  drv_wstrb [2][2];
  logic        rdy       [2][2];
  logic        rsp_v     [2][2];
  logic [31:0] rsp_d     [2][2];
  logic        rsp_e     [2][2];

  logic        m_en    [2];
  logic        m_we    [2];
  logic [3:0]  m_wstrb [2];
  logic [29:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];

  dmem_arbiter_if #(.AW(32), .DW(32)) a0 ();
  dmem_arbiter_if #(.AW(32), .DW(32)) a1 ();
  dmem_arbiter_if #(.AW(32), .DW(32)) b0 ();
  dmem_arbiter_if #(.AW(32), .DW(32)) b1 ();

`define TB_BIND(IFN, D, R) \
  assign IFN.req_valid = drv_v[D][R]; \
  assign IFN.req_we    = drv_we[D][R]; \
  assign IFN.req_addr  = drv_addr[D][R]; \
  assign IFN.req_wdata = drv_wdata[D][R]; \
  assign IFN.req_wstrb = drv_wstrb[D][R]; \
  assign rdy[D][R]     = IFN.req_ready; \
  assign rsp_v[D][R]   = IFN.rsp_valid; \
  assign rsp_d[D][R]   = IFN.rsp_rdata; \
  assign rsp_e[D][R]   = IFN.rsp_err;

  `TB_BIND(a0, 0, 0)
  `TB_BIND(a1, 0, 1)
  `TB_BIND(b0, 1, 0)
  `TB_BIND(b1, 1, 1)

  dmem_arbiter #(.AW(32), .DW(32), .MEM_DEPTH(1024), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .m0(a0), .m1(a1),
    .mem_en(m_en[0]), .mem_we(m_we[0]), .mem_wstrb(m_wstrb[0]),
    .mem_addr(m_addr[0]), .mem_wdata(m_wdata[0]), .mem_rdata(m_rdata[0])
  );

  dmem_arbiter #(.AW(32), .DW(32), .MEM_DEPTH(1024), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .m0(b0), .m1(b1),
    .mem_en(m_en[1]), .mem_we(m_we[1]), .mem_wstrb(m_wstrb[1]),
    .mem_addr(m_addr[1]), .mem_wdata(m_wdata[1]), .mem_rdata(m_rdata[1])
  );

  // Behavioural memories; read data is poisoned unless mem_en was seen at the right edge.
  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];
  logic [31:0] pa, pb0, pb1, pb2;
  logic [31:0] sh [2][1024];

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 1024; i++) begin
        mem_a[i] <= 32'h0;
        mem_b[i] <= 32'hB000_0000 + i;
      end
      mem_a[4]    <= 32'hDEAD_BEEF;
      mem_a[1023] <= 32'hCAFE_F00D;
    end
    if (m_en[0]) begin
      pa <= mem_a[m_addr[0][9:0]];
      if (m_we[0])
        for (int b = 0; b < 4; b++)
          if (m_wstrb[0][b]) mem_a[m_addr[0][9:0]][8*b +: 8] <= m_wdata[0][8*b +: 8];
    end else begin
      pa <= 32'hBAD0_BAD0;
    end
    if (m_en[1]) begin
      pb0 <= mem_b[m_addr[1][9:0]];
      if (m_we[1])
        for (int b = 0; b < 4; b++)
          if (m_wstrb[1][b]) mem_b[m_addr[1][9:0]][8*b +: 8] <= m_wdata[1][8*b +: 8];
    end else begin
      pb0 <= 32'hBAD0_BAD0;
    end
    pb1 <= pb0;
    pb2 <= pb1;
  end

  assign m_rdata[0] = pa;
  assign m_rdata[1] = pb2;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   ord_q[$];
  int   rsp_cnt [2];
  int   en_cnt  [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int d);
    exp_t        e;
    logic [1:0]  v;
    logic [1:0]  oh;
    logic [31:0] rd;
    logic        er;
    int          n;
    v = {rsp_v[d][1], rsp_v[d][0]};
    n = (d == 0) ? sb_a.size() : sb_b.size();
    if (n > 0) begin
      if (d == 0) e = sb_a[0];
      else        e = sb_b[0];
    end
    oh = (e.id != 0) ? 2'b10 : 2'b01;
    if (m_en[d]) en_cnt[d]++;
    if (v != 2'b00) begin
      rsp_cnt[d]++;
      if (n == 0) begin
        check($sformatf("rsp_unexpected_d%0d", d), v, 2'b00);
      end else begin
        if (d == 0) void'(sb_a.pop_front());
        else        void'(sb_b.pop_front());
        rd = v[1] ? rsp_d[d][1] : rsp_d[d][0];
        er = v[1] ? rsp_e[d][1] : rsp_e[d][0];
        check($sformatf("rsp_owner_d%0d", d), v, oh);
        check($sformatf("rsp_rdata_d%0d", d), rd, e.rdata);
        check($sformatf("rsp_err_d%0d", d), er, e.err);
        check($sformatf("rsp_cycle_d%0d", d), cyc, e.due);
      end
    end else if (n > 0 && cyc > e.due) begin
      check($sformatf("rsp_missing_d%0d", d), v, oh);
      if (d == 0) void'(sb_a.pop_front());
      else        void'(sb_b.pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Called at a negedge; returns at the negedge after acceptance (or on timeout).
  task automatic do_req(input int d, input int id, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb, output int acc);
    exp_t e;
    logic got;
    logic legal;
    int   budget;
    drv_v[d][id]     = 1'b1;
    drv_we[d][id]    = we;
    drv_addr[d][id]  = addr;
    drv_wdata[d][id] = wdata;
    drv_wstrb[d][id] = wstrb;
    acc    = -1;
    budget = 60;
    #1;
    while (!rdy[d][id] && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    got = rdy[d][id];
    check($sformatf("accept_d%0d_m%0d", d, id), got, 1'b1);
    if (got) begin
      acc   = cyc;
      legal = (addr < 32'h1000);
      e.id    = id;
      e.err   = !legal;
      e.rdata = 32'h0;
      if (!legal) begin
        e.due = acc + 1;
      end else if (we) begin
        e.due = acc + 2;
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) sh[d][addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        e.rdata = sh[d][addr[11:2]];
        e.due   = acc + 2 + ((d == 0) ? 1 : 3);
      end
      if (d == 0) sb_a.push_back(e);
      else        sb_b.push_back(e);
      if (d == 1) ord_q.push_back(id);
      @(negedge clk);
      check($sformatf("mem_en_d%0d", d), m_en[d], legal);
      if (legal) begin
        check($sformatf("mem_ctrl_d%0d", d), {m_we[d], m_wstrb[d], m_addr[d]}, {we, wstrb, addr[31:2]});
        check($sformatf("mem_wdata_d%0d", d), m_wdata[d], wdata);
      end
    end
    drv_v[d][id] = 1'b0;
  endtask

  task automatic drain(input int d);
    int budget;
    budget = 50;
    while (((d == 0) ? sb_a.size() : sb_b.size()) > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check($sformatf("drain_d%0d", d), (d == 0) ? sb_a.size() : sb_b.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int t0, t1, en0, rc0;
    for (int d = 0; d < 2; d++) begin
      rsp_cnt[d] = 0;
      en_cnt[d]  = 0;
      for (int r = 0; r < 2; r++) begin
        drv_v[d][r] = 1'b0; drv_we[d][r] = 1'b0; drv_addr[d][r] = '0;
        drv_wdata[d][r] = '0; drv_wstrb[d][r] = '0;
      end
    end
    for (int i = 0; i < 1024; i++) begin
      sh[0][i] = 32'h0;
      sh[1][i] = 32'hB000_0000 + i;
    end
    sh[0][4]    = 32'hDEAD_BEEF;
    sh[0][1023] = 32'hCAFE_F00D;

    // Reset state on both instances
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_rsp_d%0d", d), {rsp_v[d][0], rsp_v[d][1], rsp_e[d][0], rsp_e[d][1], rdy[d][0], rdy[d][1]}, 0);
      check($sformatf("rst_rdata_d%0d", d), {rsp_d[d][0], rsp_d[d][1]}, 0);
      check($sformatf("rst_mem_d%0d", d), {m_en[d], m_we[d], m_wstrb[d], m_addr[d]}, 0);
      check($sformatf("rst_wdata_d%0d", d), m_wdata[d], 0);
    end

    // Single read, write/read-back with strobes, unaligned low bits, zero-strobe write
    do_req(0, 0, 1'b0, 32'h10, 32'h0, 4'h0, t0);                drain(0);
    do_req(0, 1, 1'b1, 32'h20, 32'h1234_5678, 4'b0011, t0);     drain(0);
    do_req(0, 1, 1'b0, 32'h20, 32'h0, 4'h0, t0);                drain(0);
    do_req(0, 1, 1'b1, 32'h22, 32'hAABB_CCDD, 4'b1100, t0);     drain(0);
    do_req(0, 0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, t0);     drain(0);
    do_req(0, 0, 1'b0, 32'h23, 32'h0, 4'h0, t0);                drain(0);

    // Address range boundaries
    en0 = en_cnt[0];
    do_req(0, 0, 1'b0, 32'h1000, 32'h0, 4'h0, t0);              drain(0);
    do_req(0, 1, 1'b1, 32'hFFFF_FFFC, 32'h5555_5555, 4'hF, t0); drain(0);
    check("oob_no_mem_en", en_cnt[0] - en0, 0);
    do_req(0, 1, 1'b0, 32'hFFC, 32'h0, 4'h0, t0);               drain(0);
    do_req(0, 0, 1'b0, 32'h20, 32'h0, 4'h0, t0);                drain(0);

    // MEM_LAT=3: second requester is held off until the cycle after RESP
    fork
      begin do_req(1, 0, 1'b0, 32'h40, 32'h0, 4'h0, t0); end
      begin @(negedge clk); do_req(1, 1, 1'b0, 32'h44, 32'h0, 4'h0, t1); end
    join
    drain(1);
    check("lat3_block_until_idle", t1 - t0, 6);

    // Reset during ISSUE drops mem_en asynchronously
    do_req(0, 0, 1'b0, 32'h10, 32'h0, 4'h0, t0);
    rst = 1'b1;
    #1;
    check("rst_issue_mem_en", m_en[0], 1'b0);
    sb_a.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset during WAIT: pending response must never appear
    do_req(1, 0, 1'b0, 32'h48, 32'h0, 4'h0, t0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_wait_outs", {m_en[1], rsp_v[1][0], rsp_v[1][1]}, 0);
    sb_b.delete();
    rc0 = rsp_cnt[1];
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_wait_no_rsp", rsp_cnt[1] - rc0, 0);

    // Contention straight out of reset: strict alternation starting with m0
    ord_q.delete();
    rc0 = rsp_cnt[1];
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          int a;
          do_req(1, 0, 1'b0, 32'h50 + 32'(4 * k), 32'h0, 4'h0, a);
        end
      end
      begin
        for (int k = 0; k < 4; k++) begin
          int a;
          do_req(1, 1, 1'b0, 32'h60 + 32'(4 * k), 32'h0, 4'h0, a);
        end
      end
    join
    drain(1);
    check("contention_grants", ord_q.size(), 8);
    for (int k = 0; k < ord_q.size(); k++)
      check($sformatf("grant_order_%0d", k), ord_q[k], k % 2);
    check("contention_rsp_count", rsp_cnt[1] - rc0, 8);

    drain(0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
